decode_issue_queue: RTL and testbench
=====================================

Name: decode_issue_queue

Overview:
- Downstream neighbour of the D-format decoder: captures each decoded instruction it emits (enable_o strobe plus header/body fields) into a circular FIFO and presents entries to the issue stage under a valid/ready handshake.
- Drives the decoder's stall input early enough that an instruction already in flight in the decoder's one-cycle register still fits.
- Sits between the per-format decoders and issue/rename.

Parameters:
- Depth, 8, entries; power of 2, minimum 4.
- StallMargin, 2, free entries kept in reserve; stall_o asserts when count >= Depth-StallMargin.
- addressWidth, 64, instruction address width.
- opcodeSize, 12, decoded opcode width.
- funcUnitCodeSize, 3, functional-unit code width.
- instructionCounterWidth, 64, major ID width.
- instMinIdWidth, 7, minor ID width.
- PidSize, 20, process ID width.
- TidSize, 16, thread ID width.
- regAccessPatternSize, 2, operand read/write flag width.
- bodySize, 26, instruction body width (2 regs + 16-bit immediate).

Ports:
- clock_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush, drops all entries.
- enable_i  in  1  decoder output valid (push).
- opcode_i  in  opcodeSize  decoded opcode.
- instructionAddress_i  in  addressWidth  instruction address.
- functionalUnitType_i  in  funcUnitCodeSize  functional-unit code.
- instMajId_i  in  instructionCounterWidth  major ID.
- instMinId_i  in  instMinIdWidth  minor ID.
- is64Bit_i  in  1  64-bit mode flag.
- instPid_i  in  PidSize  process ID.
- instTid_i  in  TidSize  thread ID.
- op1rw_i, op2rw_i  in  regAccessPatternSize each  operand read/write flags.
- op1isReg_i, op2isReg_i, immIsExtended_i, immIsShifted_i  in  1 each  operand/immediate flags.
- instructionBody_i  in  bodySize  instruction body.
- ready_i  in  1  issue stage accepts the head entry.
- stall_o  out  1  to decoder stall_i.
- valid_o  out  1  head entry valid.
- Same-named "_o" copies of every data input above: out, same widths; head entry fields.
- count_o  out  clog2(Depth)+1  current occupancy.
- overflow_o  out  1  sticky: a push was dropped.

Behaviour:
- Entry: concatenation of all data inputs, 221 bits at defaults. Storage is a register array; a memory inference is acceptable.
- State: wrPtr and rdPtr, each clog2(Depth) bits, wrapping modulo Depth; count register.
- Reset (reset_i low, asynchronous): pointers=0, count=0, overflow_o=0, valid_o=0, stall_o=0.
  - All head data outputs read 0 while the queue is empty after reset. Array contents need no reset.
- Push = enable_i && (count<Depth || pop). Pop = valid_o && ready_i. Both evaluated on the same rising edge.
- Push writes mem[wrPtr] and increments wrPtr. Pop increments rdPtr.
- count updates +1 / -1 / unchanged; simultaneous push and pop leaves count unchanged.
- First-word-fall-through read path:
  - valid_o = (count!=0); head outputs = mem[rdPtr], combinational from registered state.
  - Push-to-valid latency is 1 cycle: an entry written at edge N appears after edge N.
  - No same-cycle bypass when empty.
- stall_o is registered from next-state count: asserts the cycle after count reaches Depth-StallMargin, deasserts the cycle after count drops below it.
- Full (count==Depth):
  - enable_i without pop: entry dropped, overflow_o set until reset or flush.
  - enable_i with pop: push accepted, count stays Depth.
- Empty: ready_i is ignored; pointers do not move.
- flush_i (synchronous, has priority over push/pop in that cycle): pointers=0, count=0, overflow_o=0, stall_o=0 next cycle.
- Reset mid-operation discards all entries; no partial update survives.
- Head outputs are held stable while valid_o=1 and ready_i=0.

Decomposition:
- Shared package holds:
  - field widths (opcodeSize, funcUnitCodeSize, PidSize, TidSize, regAccessPatternSize, bodySize);
  - functional-unit ID constants (FX=0, FP=1, VX=2, CR=3, LS=4, Branch=6);
  - regRead=2'b10 and regWrite=2'b01;
  - a packed decoded-instruction entry type, used by every format decoder and this queue.
- One sub-module, circular_fifo (Depth, Width): generic storage, pointers and count.
- The top level packs and unpacks fields and adds stall, overflow and flush.

Test Plan:
- Reset then push one entry (majId=5, opcode=12'h00E), ready_i=0 -> valid_o=1 one cycle later, instMajId_o=5, count_o=1, stall_o=0.
- Push 6 entries (majId 0..5), ready_i=0, Depth=8, StallMargin=2 -> stall_o=1 the cycle after the 6th push; count_o=6.
- Continue pushing to 8 entries, then a 9th -> count_o=8; 9th dropped; overflow_o=1; head still majId 0.
- Full queue, enable_i=1 and ready_i=1 same cycle -> head advances to majId 1, new entry accepted, count_o stays 8.
- Push 3, pop all with ready_i=1 across wrap (start with wrPtr=6) -> output order majId preserved; valid_o=0 after last; count_o=0.
- Push 4 then assert flush_i; separately, assert reset_i low between clock edges -> both give count_o=0, valid_o=0, overflow_o=0, stall_o=0. The reset case takes effect immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_issue_queue_pkg.sv
// Field widths, functional-unit codes and the packed decoded-instruction entry
// shared by the per-format decoders and the decode issue queue.
package decode_issue_queue_pkg;

    localparam int unsigned addressWidth            = 64;
    localparam int unsigned opcodeSize              = 12;
    localparam int unsigned funcUnitCodeSize        = 3;
    localparam int unsigned instructionCounterWidth = 64;
    localparam int unsigned instMinIdWidth          = 7;
    localparam int unsigned PidSize                 = 20;
    localparam int unsigned TidSize                 = 16;
    localparam int unsigned regAccessPatternSize    = 2;
    localparam int unsigned bodySize                = 26;

    localparam logic [funcUnitCodeSize-1:0] FX     = 3'd0;
    localparam logic [funcUnitCodeSize-1:0] FP     = 3'd1;
    localparam logic [funcUnitCodeSize-1:0] VX     = 3'd2;
    localparam logic [funcUnitCodeSize-1:0] CR     = 3'd3;
    localparam logic [funcUnitCodeSize-1:0] LS     = 3'd4;
    localparam logic [funcUnitCodeSize-1:0] Branch = 3'd6;

    localparam logic [regAccessPatternSize-1:0] regRead  = 2'b10;
    localparam logic [regAccessPatternSize-1:0] regWrite = 2'b01;

    typedef struct packed {
        logic [opcodeSize-1:0]              opcode;
        logic [addressWidth-1:0]            instructionAddress;
        logic [funcUnitCodeSize-1:0]        functionalUnitType;
        logic [instructionCounterWidth-1:0] instMajId;
        logic [instMinIdWidth-1:0]          instMinId;
        logic                               is64Bit;
        logic [PidSize-1:0]                 instPid;
        logic [TidSize-1:0]                 instTid;
        logic [regAccessPatternSize-1:0]    op1rw;
        logic [regAccessPatternSize-1:0]    op2rw;
        logic                               op1isReg;
        logic                               op2isReg;
        logic                               immIsExtended;
        logic                               immIsShifted;
        logic [bodySize-1:0]                instructionBody;
    } decoded_inst_t;

    localparam int unsigned DecodedInstWidth = $bits(decoded_inst_t);

endpackage

// File: rtl/decode_issue_queue_fifo.sv
// Generic first-word-fall-through circular FIFO: storage, wrapping pointers and
// occupancy count, with a push that is still accepted when full if a pop coincides.
module circular_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_ready,
    input  logic [Width-1:0]         i_wdata,
    output logic [Width-1:0]         o_rdata,
    output logic                     o_valid,
    output logic [$clog2(Depth):0]   o_count,
    output logic                     o_push,
    output logic                     o_pop
);
    localparam int unsigned AW = $clog2(Depth);
    localparam logic [AW:0] FullCount = (AW+1)'(Depth);
    localparam logic [AW:0] OneCount  = (AW+1)'(1);
    localparam logic [AW-1:0] OnePtr  = AW'(1);

    logic [Width-1:0] r_mem [Depth];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = (r_count != '0) && i_ready;
    assign w_push = i_push && ((r_count < FullCount) || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + OnePtr;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + OnePtr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OneCount;
                2'b01:   r_count <= r_count - OneCount;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

    // Gating with valid keeps the head fields at zero whenever the queue is empty.
    assign o_rdata = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_valid = (r_count != '0);
    assign o_count = r_count;
    assign o_push  = w_push && !i_flush;
    assign o_pop   = w_pop && !i_flush;

endmodule

// File: rtl/decode_issue_queue.sv
// Issue queue behind the D-format decoder: packs decoded fields into a FIFO entry,
// presents the head to issue, and raises an early stall plus a sticky overflow flag.
module decode_issue_queue #(
    parameter int unsigned Depth                   = 8,
    parameter int unsigned StallMargin             = 2,
    parameter int unsigned addressWidth            = decode_issue_queue_pkg::addressWidth,
    parameter int unsigned opcodeSize              = decode_issue_queue_pkg::opcodeSize,
    parameter int unsigned funcUnitCodeSize        = decode_issue_queue_pkg::funcUnitCodeSize,
    parameter int unsigned instructionCounterWidth = decode_issue_queue_pkg::instructionCounterWidth,
    parameter int unsigned instMinIdWidth          = decode_issue_queue_pkg::instMinIdWidth,
    parameter int unsigned PidSize                 = decode_issue_queue_pkg::PidSize,
    parameter int unsigned TidSize                 = decode_issue_queue_pkg::TidSize,
    parameter int unsigned regAccessPatternSize    = decode_issue_queue_pkg::regAccessPatternSize,
    parameter int unsigned bodySize                = decode_issue_queue_pkg::bodySize
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               flush_i,
    input  logic                               enable_i,
    input  logic [opcodeSize-1:0]              opcode_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic [funcUnitCodeSize-1:0]        functionalUnitType_i,
    input  logic [instructionCounterWidth-1:0] instMajId_i,
    input  logic [instMinIdWidth-1:0]          instMinId_i,
    input  logic                               is64Bit_i,
    input  logic [PidSize-1:0]                 instPid_i,
    input  logic [TidSize-1:0]                 instTid_i,
    input  logic [regAccessPatternSize-1:0]    op1rw_i,
    input  logic [regAccessPatternSize-1:0]    op2rw_i,
    input  logic                               op1isReg_i,
    input  logic                               op2isReg_i,
    input  logic                               immIsExtended_i,
    input  logic                               immIsShifted_i,
    input  logic [bodySize-1:0]                instructionBody_i,
    input  logic                               ready_i,
    output logic                               stall_o,
    output logic                               valid_o,
    output logic [opcodeSize-1:0]              opcode_o,
    output logic [addressWidth-1:0]            instructionAddress_o,
    output logic [funcUnitCodeSize-1:0]        functionalUnitType_o,
    output logic [instructionCounterWidth-1:0] instMajId_o,
    output logic [instMinIdWidth-1:0]          instMinId_o,
    output logic                               is64Bit_o,
    output logic [PidSize-1:0]                 instPid_o,
    output logic [TidSize-1:0]                 instTid_o,
    output logic [regAccessPatternSize-1:0]    op1rw_o,
    output logic [regAccessPatternSize-1:0]    op2rw_o,
    output logic                               op1isReg_o,
    output logic                               op2isReg_o,
    output logic                               immIsExtended_o,
    output logic                               immIsShifted_o,
    output logic [bodySize-1:0]                instructionBody_o,
    output logic [$clog2(Depth):0]             count_o,
    output logic                               overflow_o
);
    import decode_issue_queue_pkg::*;

    localparam int unsigned CW = $clog2(Depth) + 1;
    localparam int unsigned EntryWidth = opcodeSize + addressWidth + funcUnitCodeSize
        + instructionCounterWidth + instMinIdWidth + 1 + PidSize + TidSize
        + 2*regAccessPatternSize + 4 + bodySize;
    localparam logic [CW-1:0] StallLevel = CW'(Depth - StallMargin);
    localparam logic [CW-1:0] OneCount   = CW'(1);

    logic [EntryWidth-1:0] w_wdata;
    logic [EntryWidth-1:0] w_rdata;
    logic [CW-1:0]         w_count;
    logic [CW-1:0]         w_count_next;
    logic                  w_push;
    logic                  w_pop;
    logic                  r_stall;
    logic                  r_overflow;

    assign w_wdata = {opcode_i, instructionAddress_i, functionalUnitType_i, instMajId_i,
                      instMinId_i, is64Bit_i, instPid_i, instTid_i, op1rw_i, op2rw_i,
                      op1isReg_i, op2isReg_i, immIsExtended_i, immIsShifted_i,
                      instructionBody_i};

    circular_fifo #(
        .Depth (Depth),
        .Width (EntryWidth)
    ) u_fifo (
        .i_clk   (clock_i),
        .i_rst_n (reset_i),
        .i_flush (flush_i),
        .i_push  (enable_i),
        .i_ready (ready_i),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata),
        .o_valid (valid_o),
        .o_count (w_count),
        .o_push  (w_push),
        .o_pop   (w_pop)
    );

    assign {opcode_o, instructionAddress_o, functionalUnitType_o, instMajId_o,
            instMinId_o, is64Bit_o, instPid_o, instTid_o, op1rw_o, op2rw_o,
            op1isReg_o, op2isReg_o, immIsExtended_o, immIsShifted_o,
            instructionBody_o} = w_rdata;

    always_comb begin
        w_count_next = w_count;
        if (flush_i)              w_count_next = '0;
        else if (w_push && !w_pop) w_count_next = w_count + OneCount;
        else if (!w_push && w_pop) w_count_next = w_count - OneCount;
    end

    // Stall follows next-state occupancy so the decoder's in-flight instruction still fits.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_stall    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_stall <= (w_count_next >= StallLevel);
            if (flush_i)               r_overflow <= 1'b0;
            else if (enable_i && !w_push) r_overflow <= 1'b1;
        end
    end

    assign stall_o    = r_stall;
    assign overflow_o = r_overflow;
    assign count_o    = w_count;

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue with a queue-based scoreboard of expected entries.
module tb_decode_issue_queue;

    logic         clock_i = 1'b0;
    logic         reset_i;
    logic         flush_i;
    logic         enable_i;
    logic [11:0]  opcode_i;
    logic [63:0]  instructionAddress_i;
    logic [2:0]   functionalUnitType_i;
    logic [63:0]  instMajId_i;
    logic [6:0]   instMinId_i;
    logic         is64Bit_i;
    logic [19:0]  instPid_i;
    logic [15:0]  instTid_i;
    logic [1:0]   op1rw_i, op2rw_i;
    logic         op1isReg_i, op2isReg_i, immIsExtended_i, immIsShifted_i;
    logic [25:0]  instructionBody_i;
    logic         ready_i;
    logic         stall_o, valid_o;
    logic [11:0]  opcode_o;
    logic [63:0]  instructionAddress_o;
    logic [2:0]   functionalUnitType_o;
    logic [63:0]  instMajId_o;
    logic [6:0]   instMinId_o;
    logic         is64Bit_o;
    logic [19:0]  instPid_o;
    logic [15:0]  instTid_o;
    logic [1:0]   op1rw_o, op2rw_o;
    logic         op1isReg_o, op2isReg_o, immIsExtended_o, immIsShifted_o;
    logic [25:0]  instructionBody_o;
    logic [3:0]   count_o;
    logic         overflow_o;

    always #5 clock_i = ~clock_i;

    decode_issue_queue #(
        .Depth       (8),
        .StallMargin (2)
    ) dut (
        .clock_i              (clock_i),
        .reset_i              (reset_i),
        .flush_i              (flush_i),
        .enable_i             (enable_i),
        .opcode_i             (opcode_i),
        .instructionAddress_i (instructionAddress_i),
        .functionalUnitType_i (functionalUnitType_i),
        .instMajId_i          (instMajId_i),
        .instMinId_i          (instMinId_i),
        .is64Bit_i            (is64Bit_i),
        .instPid_i            (instPid_i),
        .instTid_i            (instTid_i),
        .op1rw_i              (op1rw_i),
        .op2rw_i              (op2rw_i),
        .op1isReg_i           (op1isReg_i),
        .op2isReg_i           (op2isReg_i),
        .immIsExtended_i      (immIsExtended_i),
        .immIsShifted_i       (immIsShifted_i),
        .instructionBody_i    (instructionBody_i),
        .ready_i              (ready_i),
        .stall_o              (stall_o),
        .valid_o              (valid_o),
        .opcode_o             (opcode_o),
        .instructionAddress_o (instructionAddress_o),
        .functionalUnitType_o (functionalUnitType_o),
        .instMajId_o          (instMajId_o),
        .instMinId_o          (instMinId_o),
        .is64Bit_o            (is64Bit_o),
        .instPid_o            (instPid_o),
        .instTid_o            (instTid_o),
        .op1rw_o              (op1rw_o),
        .op2rw_o              (op2rw_o),
        .op1isReg_o           (op1isReg_o),
        .op2isReg_o           (op2isReg_o),
        .immIsExtended_o      (immIsExtended_o),
        .immIsShifted_o       (immIsShifted_o),
        .instructionBody_o    (instructionBody_o),
        .count_o              (count_o),
        .overflow_o           (overflow_o)
    );

    typedef struct {
        logic [63:0] mid;
        logic [11:0] opc;
        logic [25:0] body;
        logic [63:0] addr;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic ovf_m = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("count", 64'(count_o), 64'(sb.size()));
        chk("valid", 64'(valid_o), 64'(sb.size() != 0));
        chk("stall", 64'(stall_o), 64'(sb.size() >= 6));
        chk("overflow", 64'(overflow_o), 64'(ovf_m));
        if (sb.size() != 0) chk("head_majid", instMajId_o, sb[0].mid);
    endtask

    // One clock: drive at the falling edge, update the model, check after the rising edge.
    task automatic cycle(input bit fl, input bit en, input bit rdy,
                         input logic [63:0] mid, input logic [11:0] opc);
        exp_t e;
        bit   pop, push;
        @(negedge clock_i);
        e.mid  = mid;
        e.opc  = opc;
        e.body = mid[25:0] ^ 26'h2A5_5A5;
        e.addr = 64'h1000 + (mid << 2);
        flush_i = fl; enable_i = en; ready_i = rdy;
        instMajId_i = e.mid; opcode_i = e.opc;
        instructionBody_i = e.body; instructionAddress_i = e.addr;
        instMinId_i = mid[6:0]; instPid_i = 20'h12345; instTid_i = 16'hBEEF;
        pop  = !fl && (sb.size() != 0) && rdy;
        push = !fl && en && ((sb.size() < 8) || pop);
        if (fl) begin
            sb.delete();
            ovf_m = 1'b0;
        end else begin
            if (pop) begin
                chk("pop_majid", instMajId_o, sb[0].mid);
                chk("pop_opcode", 64'(opcode_o), 64'(sb[0].opc));
                chk("pop_body", 64'(instructionBody_o), 64'(sb[0].body));
                chk("pop_addr", instructionAddress_o, sb[0].addr);
                void'(sb.pop_front());
            end
            if (push) sb.push_back(e);
            else if (en) ovf_m = 1'b1;
        end
        @(posedge clock_i);
        #1;
        check_state();
    endtask

    initial begin
        reset_i = 1'b0; flush_i = 1'b0; enable_i = 1'b0; ready_i = 1'b0;
        opcode_i = '0; instructionAddress_i = '0; functionalUnitType_i = 3'd4;
        instMajId_i = '0; instMinId_i = '0; is64Bit_i = 1'b1; instPid_i = '0;
        instTid_i = '0; op1rw_i = 2'b10; op2rw_i = 2'b01; op1isReg_i = 1'b1;
        op2isReg_i = 1'b0; immIsExtended_i = 1'b1; immIsShifted_i = 1'b0;
        instructionBody_i = '0;
        #3;
        check_state();
        chk("reset_head_opcode", 64'(opcode_o), 64'h0);
        chk("reset_head_majid", instMajId_o, 64'h0);
        @(negedge clock_i);
        reset_i = 1'b1;

        // Single entry, not accepted by issue; then drained.
        cycle(0, 1, 0, 64'd5, 12'h00E);
        chk("single_opcode", 64'(opcode_o), 64'h00E);
        cycle(0, 0, 1, 64'd0, 12'h000);

        // Fill to the stall level, then full, then a dropped push.
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 64'(i), 12'h100 + 12'(i));
        chk("stall_at_6", 64'(stall_o), 64'h1);
        cycle(0, 1, 0, 64'd6, 12'h106);
        cycle(0, 1, 0, 64'd7, 12'h107);
        cycle(0, 1, 0, 64'd8, 12'h108);
        chk("full_overflow", 64'(overflow_o), 64'h1);
        chk("full_head", instMajId_o, 64'd0);

        // Full with simultaneous push and pop.
        cycle(0, 1, 1, 64'd9, 12'h109);
        chk("full_pushpop_head", instMajId_o, 64'd1);
        chk("full_pushpop_count", 64'(count_o), 64'd8);

        // Flush of a full, overflowed queue.
        cycle(1, 1, 1, 64'd10, 12'h10A);
        chk("flush_count", 64'(count_o), 64'd0);

        // Move both pointers to 6, then push three across the wrap and drain.
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 64'(20 + i), 12'h200 + 12'(i));
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, 64'd0, 12'h000);
        cycle(0, 0, 1, 64'd0, 12'h000);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 64'(30 + i), 12'h300 + 12'(i));
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 64'd0, 12'h000);
        chk("wrap_empty_valid", 64'(valid_o), 64'h0);

        // Push four, then flush.
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 64'(40 + i), 12'h400 + 12'(i));
        cycle(1, 0, 0, 64'd0, 12'h000);

        // Push six with an overflowing attempt never reached; reset between edges.
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 64'(50 + i), 12'h500 + 12'(i));
        chk("pre_reset_stall", 64'(stall_o), 64'h1);
        @(negedge clock_i);
        enable_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
        #2;
        reset_i = 1'b0;
        #1;
        sb.delete();
        ovf_m = 1'b0;
        check_state();
        chk("async_reset_head", instMajId_o, 64'h0);
        @(negedge clock_i);
        reset_i = 1'b1;
        cycle(0, 1, 0, 64'd77, 12'h077);
        cycle(0, 0, 1, 64'd0, 12'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
